gpio_change_tx: RTL and testbench

// - Device-side transmitter for a GPIO bridge: watches a wide parallel input bus and sends a snapshot

---
 rtl/gpio_change_tx.sv | 141 ++++++++++++++
 tb/tb_gpio_change_tx.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_change_tx.sv
// gpio_change_tx: synchronizes a wide GPIO bus and streams it as DW-bit beats on change or on request.
// Defining GPIO_CHANGE_TX_SEQ_EN adds a per-snapshot sequence number output (seq_num).
module gpio_change_tx #(
    parameter int unsigned IWIDTH      = 128,
    parameter int unsigned DW          = 32,
    parameter int unsigned SYNC_STAGES = 2,
    localparam int unsigned NB = (IWIDTH + DW - 1) / DW,
    localparam int unsigned IW = $clog2(NB) + 1
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic [IWIDTH-1:0] gpio_in,
    input  logic              enable,
    input  logic              force_send,
    input  logic              clear_ovf,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DW-1:0]     out_data,
    output logic [IW-1:0]     out_index,
    output logic              out_last,
    output logic              busy,
    output logic              overflow
`ifdef GPIO_CHANGE_TX_SEQ_EN
    ,
    output logic [7:0]        seq_num
`endif
);

    localparam int unsigned PW = NB * DW;

    typedef enum logic {IDLE, SEND} state_t;

    state_t                               state;
    logic [SYNC_STAGES-1:0][IWIDTH-1:0]   sync_ff;
    logic [IWIDTH-1:0]                    sync;
    logic [IWIDTH-1:0]                    sync_q;
    logic [IWIDTH-1:0]                    last_sent;
    logic [PW-1:0]                        sync_pad;
    logic [PW-1:0]                        snapshot;
    logic                                 pending;
    logic                                 capture;
    logic                                 handshake;
    logic                                 last_beat;
    logic                                 sync_change;
    logic                                 ovf_set;
    logic [IW-1:0]                        next_index;

    function automatic logic [DW-1:0] beat_at(input logic [PW-1:0] v, input logic [IW-1:0] idx);
        beat_at = '0;
        for (int unsigned b = 0; b < NB; b++) begin
            if (idx == IW'(b)) beat_at = v[b*DW +: DW];
        end
    endfunction

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            sync_ff <= '0;
            sync_q  <= '0;
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], gpio_in};
            sync_q  <= sync;
        end
    end

    assign sync        = sync_ff[SYNC_STAGES-1];
    // Zero-extend so the top beat reads 0 above IWIDTH.
    assign sync_pad    = PW'(sync);
    assign capture     = (state == IDLE) && enable && ((sync != last_sent) || force_send);
    assign handshake   = out_valid && out_ready;
    assign last_beat   = (out_index == IW'(NB - 1));
    assign next_index  = out_index + 1'b1;
    assign sync_change = (sync != sync_q);
    assign ovf_set     = (state == SEND) && sync_change && pending;
    assign busy        = (state == SEND);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state     <= IDLE;
            snapshot  <= '0;
            last_sent <= '0;
            pending   <= 1'b0;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_index <= '0;
            out_last  <= 1'b0;
        end else begin
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (clear_ovf) begin
                overflow <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (capture) begin
                        snapshot  <= sync_pad;
                        last_sent <= sync;
                        pending   <= 1'b0;
                        out_index <= '0;
                        out_data  <= sync_pad[DW-1:0];
                        out_last  <= (NB == 1);
                        out_valid <= 1'b1;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (sync_change) pending <= 1'b1;
                    if (handshake) begin
                        if (last_beat) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            out_index <= next_index;
                            out_data  <= beat_at(snapshot, next_index);
                            out_last  <= (next_index == IW'(NB - 1));
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef GPIO_CHANGE_TX_SEQ_EN
    logic seq_started;

    // The first capture after reset keeps 0; later captures advance the count.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            seq_num     <= '0;
            seq_started <= 1'b0;
        end else if (capture) begin
            if (seq_started) seq_num <= seq_num + 8'd1;
            seq_started <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_gpio_change_tx.sv
// Scoreboard bench for gpio_change_tx (IWIDTH=128, DW=32, SYNC_STAGES=2).
// Expected beats are queued when stimulus is applied and popped as the DUT hands them over.
module tb_gpio_change_tx;

    logic         clk = 1'b0;
    logic         nreset;
    logic [127:0] gpio_in;
    logic         enable;
    logic         force_send;
    logic         clear_ovf;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_data;
    logic [2:0]   out_index;
    logic         out_last;
    logic         busy;
    logic         overflow;
`ifdef GPIO_CHANGE_TX_SEQ_EN
    logic [7:0]   seq_num;
`endif

    gpio_change_tx #(.IWIDTH(128), .DW(32), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .nreset     (nreset),
        .gpio_in    (gpio_in),
        .enable     (enable),
        .force_send (force_send),
        .clear_ovf  (clear_ovf),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_index  (out_index),
        .out_last   (out_last),
        .busy       (busy),
        .overflow   (overflow)
`ifdef GPIO_CHANGE_TX_SEQ_EN
        ,
        .seq_num    (seq_num)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [2:0]  idx;
        logic        last;
        logic [7:0]  seq;
    } beat_t;

    beat_t sbq[$];
    int    checks = 0;
    int    errors = 0;
    int    snap_n = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_snap(input logic [127:0] v);
        beat_t b;
        for (int i = 0; i < 4; i++) begin
            b.data = v[i*32 +: 32];
            b.idx  = 3'(i);
            b.last = (i == 3);
            b.seq  = 8'(snap_n);
            sbq.push_back(b);
        end
        snap_n++;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_force();
        force_send = 1'b1;
        tick(1);
        force_send = 1'b0;
    endtask

    task automatic wait_drain(input int limit);
        int cnt = 0;
        while ((sbq.size() != 0 || busy) && cnt < limit) begin
            tick(1);
            cnt++;
        end
        check("drain_queue", 128'(sbq.size()), 128'd0);
        check("drain_busy", 128'(busy), 128'd0);
    endtask

    // Beats are taken at the falling edge ahead of the accepting rising edge.
    always @(negedge clk) begin
        beat_t b;
        if (nreset && out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                check("unexpected_beat", 128'(out_data), 128'h0 - 1);
            end else begin
                b = sbq.pop_front();
                check("beat_data", 128'(out_data), 128'(b.data));
                check("beat_index", 128'(out_index), 128'(b.idx));
                check("beat_last", 128'(out_last), 128'(b.last));
`ifdef GPIO_CHANGE_TX_SEQ_EN
                check("beat_seq", 128'(seq_num), 128'(b.seq));
`endif
            end
        end
    end

    initial begin
        int cnt;
        nreset     = 1'b0;
        gpio_in    = '0;
        enable     = 1'b1;
        force_send = 1'b0;
        clear_ovf  = 1'b0;
        out_ready  = 1'b1;
        tick(2);
        check("rst_valid", 128'(out_valid), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_ovf", 128'(overflow), 128'd0);
        check("rst_data", 128'(out_data), 128'd0);
        check("rst_index", 128'(out_index), 128'd0);
        nreset = 1'b1;
        tick(50);
        check("idle_valid", 128'(out_valid), 128'd0);
        check("idle_busy", 128'(busy), 128'd0);
        check("idle_ovf", 128'(overflow), 128'd0);

        // Single-bit change and synchronizer latency.
        gpio_in = 128'h1;
        push_snap(gpio_in);
        tick(2);
        check("lat_early", 128'(out_valid), 128'd0);
        tick(1);
        check("lat_valid", 128'(out_valid), 128'd1);
        wait_drain(40);

        // Backpressure on beat 1.
        gpio_in = 128'h44444444_33333333_22222222_11111111;
        push_snap(gpio_in);
        cnt = 0;
        while (!(out_valid && out_index == 3'd1) && cnt < 40) begin
            tick(1);
            cnt++;
        end
        check("reach_beat1", 128'(out_index), 128'd1);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check("stall_valid", 128'(out_valid), 128'd1);
            check("stall_index", 128'(out_index), 128'd1);
            check("stall_data", 128'(out_data), 128'h22222222);
        end
        out_ready = 1'b1;
        wait_drain(40);

        // A single change during SEND is coalesced without overflow.
        out_ready = 1'b0;
        gpio_in = 128'h1;
        push_snap(gpio_in);
        cnt = 0;
        while (!busy && cnt < 40) begin
            tick(1);
            cnt++;
        end
        check("send_started", 128'(busy), 128'd1);
        gpio_in = 128'h2;
        tick(4);
        check("ovf_single", 128'(overflow), 128'd0);
        push_snap(128'h2);
        out_ready = 1'b1;
        wait_drain(60);
        check("ovf_after_two", 128'(overflow), 128'd0);

        // Two changes during one SEND overflow; only the final value is sent.
        out_ready = 1'b0;
        pulse_force();
        push_snap(128'h2);
        check("force_busy", 128'(busy), 128'd1);
        gpio_in = 128'h3;
        tick(4);
        gpio_in = 128'h4;
        tick(4);
        check("ovf_set", 128'(overflow), 128'd1);
        push_snap(128'h4);
        out_ready = 1'b1;
        wait_drain(60);
        check("ovf_sticky", 128'(overflow), 128'd1);
        clear_ovf = 1'b1;
        tick(1);
        clear_ovf = 1'b0;
        check("ovf_cleared", 128'(overflow), 128'd0);

        // force_send with steady input, then disabled.
        gpio_in = 128'hA5;
        push_snap(gpio_in);
        wait_drain(40);
        pulse_force();
        push_snap(128'hA5);
        wait_drain(40);
        enable = 1'b0;
        gpio_in = 128'h5A;
        tick(20);
        pulse_force();
        tick(10);
        check("disabled_busy", 128'(busy), 128'd0);
        check("disabled_valid", 128'(out_valid), 128'd0);

        // Asynchronous reset during beat 2.
        push_snap(128'h5A);
        enable = 1'b1;
        cnt = 0;
        while (!(out_valid && out_index == 3'd2) && cnt < 40) begin
            tick(1);
            cnt++;
        end
        check("reach_beat2", 128'(out_index), 128'd2);
        nreset = 1'b0;
        #1;
        check("async_valid", 128'(out_valid), 128'd0);
        check("async_index", 128'(out_index), 128'd0);
        check("async_busy", 128'(busy), 128'd0);
        sbq.delete();
        snap_n = 0;
        tick(2);
        nreset = 1'b1;
        push_snap(128'h5A);
        wait_drain(40);

`ifdef GPIO_CHANGE_TX_SEQ_EN
        // Walk the sequence number through its wrap.
        for (int i = 0; i < 257; i++) begin
            pulse_force();
            push_snap(128'h5A);
            wait_drain(40);
        end
        check("seq_wrapped", 128'(seq_num), 128'd1);
`endif

        tick(5);
        check("final_queue", 128'(sbq.size()), 128'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1);
    end

endmodule
